// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Types and constants shared by the SRAM arbiter and its winner picker.
//
//   arb_state_e : access sequencer states (IDLE -> SETUP -> ACCESS -> DONE)
//   MODE_FIXED  : fixed priority, port 0 highest
//   MODE_RR     : round-robin, search starts after the last winner
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width of a port index / round-robin pointer. Kept at least 1 bit so the
  // pointer register always exists.
  function automatic int port_idx_width(input int nports);
    return (nports > 2) ? $clog2(nports) : 1;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational winner selection for the SRAM arbiter.
//
//   req     [NPORTS-1:0] : requesting ports
//   ptr     [PW-1:0]     : index of the previous winner (round-robin only)
//   mode_rr              : 1 = round-robin, 0 = fixed priority
//   winner  [NPORTS-1:0] : one-hot winner, zero when nothing is requested
// -----------------------------------------------------------------------------
module arb_pick #(
  parameter int NPORTS = 2,
  parameter int PW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  input  logic              mode_rr,
  output logic [NPORTS-1:0] winner
);

  logic [NPORTS-1:0] fixed_win;
  logic [NPORTS-1:0] rr_win;

  // Fixed priority: a port wins when no lower-indexed port is requesting.
  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_fixed
      if (gi == 0) begin : g_first
        assign fixed_win[gi] = req[gi];
      end else begin : g_rest
        assign fixed_win[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  // Round-robin: walk ptr+1, ptr+2, ... wrapping, so the previous winner is
  // considered last and only wins again when it is the sole requester.
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    rr_win = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = PW'((int'(ptr) + k) % NPORTS);
      if (!found && req[idx]) begin
        rr_win[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign winner = mode_rr ? rr_win : fixed_win;

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates NPORTS requesters onto one asynchronous SRAM. Each access runs
//   IDLE -> SETUP (1 cycle) -> ACCESS (ACCESS_CYCLES) -> DONE (1 cycle).
//   The requester's address, direction and write data are latched at grant,
//   so request-side changes mid-access have no effect.
//
//   Parameters
//     NPORTS        : requester count (2..4)
//     AW, DW        : SRAM address / data width
//     MODE          : MODE_FIXED or MODE_RR
//     ACCESS_CYCLES : cycles with the SRAM strobe active (1..4)
//
//   Ports
//     clk_in, b_reset       : clock, asynchronous active-low reset
//     req, rw, addr, wdata  : per-port request, 1=read, address, write data
//     rdata                 : last read data, valid while ack is high
//     ack                   : one-hot completion strobe (DONE cycle)
//     grant                 : one-hot owner of the access in flight
//     busy                  : sequencer not in IDLE
//     sram_*                : SRAM pins; the DQ tristate buffer sits at the
//                             chip top, this block only supplies dq_o / dq_oe
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS        = 2,
  parameter int AW            = 17,
  parameter int DW            = 8,
  parameter int MODE          = 0,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 b_reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    rw,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [DW-1:0]        rdata,
  output logic [NPORTS-1:0]    ack,
  output logic [NPORTS-1:0]    grant,
  output logic                 busy,
  output logic [AW-1:0]        sram_ad,
  output logic [DW-1:0]        sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [DW-1:0]        sram_dq_i,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_cs
);

  localparam int         PW       = port_idx_width(NPORTS);
  // Value of the strobe counter in the final ACCESS cycle.
  localparam logic [1:0] LAST_CNT = 2'(ACCESS_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic              rw_q, rw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NPORTS-1:0] winner;

  arb_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .mode_rr (MODE == MODE_RR),
    .winner  (winner)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ptr_q   <= PW'(NPORTS - 1);  // so port 0 is first in round-robin order
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;

    ack        = '0;
    grant      = '0;
    sram_cs    = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_SETUP;
          grant_d = winner;
          for (int i = 0; i < NPORTS; i++) begin
            if (winner[i]) begin
              rw_d    = rw[i];
              addr_d  = addr[i*AW +: AW];
              wdata_d = wdata[i*DW +: DW];
              ptr_d   = PW'(i);
            end
          end
        end
      end

      ST_SETUP: begin
        // Address settles with both strobes off; writes already drive DQ.
        grant      = grant_q;
        sram_cs    = 1'b1;
        sram_dq_oe = ~rw_q;
        cnt_d      = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        grant      = grant_q;
        sram_cs    = 1'b1;
        sram_dq_oe = ~rw_q;
        sram_oe_n  = ~rw_q;
        sram_we_n  = rw_q;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          // Read data is sampled at the edge that ends the strobe.
          if (rw_q) begin
            rdata_d = sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DONE: begin
        // Strobes off, DQ still driven for write hold time.
        grant      = grant_q;
        ack        = grant_q;
        sram_cs    = 1'b1;
        sram_dq_oe = ~rw_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign rdata     = rdata_q;
  assign sram_ad   = addr_q;
  assign sram_dq_o = wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   dut0: NPORTS=2, fixed priority, ACCESS_CYCLES=2
//   dut1: NPORTS=4, round-robin,    ACCESS_CYCLES=2
//   Stimulus pushes the expected completion of every access into a per-DUT
//   queue; a monitor per DUT follows the SRAM pins each cycle and pops/compares
//   when ack rises.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]    ack;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdv;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // ---------------- dut0 ----------------
  logic          rst0_n;
  logic [1:0]    req0, rw0, ack0, grant0;
  logic [2*AW-1:0] addr0;
  logic [2*DW-1:0] wdata0;
  logic [DW-1:0] rdata0, dq_o0, dq_i0;
  logic [AW-1:0] ad0;
  logic          busy0, dq_oe0, we_n0, oe_n0, cs0;

  mem_arbiter #(.NPORTS(2), .AW(AW), .DW(DW), .MODE(0), .ACCESS_CYCLES(2)) dut0 (
    .clk_in(clk), .b_reset(rst0_n), .req(req0), .rw(rw0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .grant(grant0), .busy(busy0),
    .sram_ad(ad0), .sram_dq_o(dq_o0), .sram_dq_oe(dq_oe0), .sram_dq_i(dq_i0),
    .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_cs(cs0)
  );

  // ---------------- dut1 ----------------
  logic          rst1_n;
  logic [3:0]    req1, rw1, ack1, grant1;
  logic [4*AW-1:0] addr1;
  logic [4*DW-1:0] wdata1;
  logic [DW-1:0] rdata1, dq_o1, dq_i1;
  logic [AW-1:0] ad1;
  logic          busy1, dq_oe1, we_n1, oe_n1, cs1;

  mem_arbiter #(.NPORTS(4), .AW(AW), .DW(DW), .MODE(1), .ACCESS_CYCLES(2)) dut1 (
    .clk_in(clk), .b_reset(rst1_n), .req(req1), .rw(rw1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ack(ack1), .grant(grant1), .busy(busy1),
    .sram_ad(ad1), .sram_dq_o(dq_o1), .sram_dq_oe(dq_oe1), .sram_dq_i(dq_i1),
    .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_cs(cs1)
  );

  // ---------------- checking ----------------
  task automatic chk(input int id, input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h", id, name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input int p, input logic rd, input logic [AW-1:0] a,
                                  input logic [DW-1:0] wd, input logic [DW-1:0] rdv);
    exp_t e;
    e.ack  = 4'(1 << p);
    e.rd   = rd;
    e.addr = a;
    e.wd   = wd;
    e.rdv  = rdv;
    return e;
  endfunction

  // Per-access tallies, indexed by DUT.
  int cs_cnt[2];
  int stb_cnt[2];
  int err_cnt[2];

  task automatic mon_step(input int id, input logic rst_n, input logic [3:0] ack,
                          input logic [3:0] grant, input logic cs, input logic we_n,
                          input logic oe_n, input logic dq_oe, input logic [AW-1:0] ad,
                          input logic [DW-1:0] dq_o, input logic [DW-1:0] rd);
    exp_t e;
    logic have;
    if (!rst_n) begin
      cs_cnt[id]  = 0;
      stb_cnt[id] = 0;
      err_cnt[id] = 0;
    end else begin
      have = (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
      e = '0;
      if (have) e = (id == 0) ? q0[0] : q1[0];
      chk(id, "strobe_excl", {31'd0, we_n | oe_n}, 32'd1);
      chk(id, "ack_grant_1hot", {31'd0, ($countones(ack) <= 1) && ($countones(grant) <= 1)}, 32'd1);
      if (!cs) begin
        chk(id, "idle_pins", {29'd0, we_n, oe_n, dq_oe}, 32'b110);
      end else if (have) begin
        cs_cnt[id]++;
        if (ad != e.addr) err_cnt[id]++;
        if (e.rd) begin
          if (!oe_n) stb_cnt[id]++;
          if (!we_n || dq_oe) err_cnt[id]++;
        end else begin
          if (!we_n) stb_cnt[id]++;
          if (!oe_n || !dq_oe || dq_o != e.wd) err_cnt[id]++;
        end
      end
      if (ack != 4'd0) begin
        if (!have) begin
          chk(id, "unexpected_ack", {28'd0, ack}, 32'd0);
        end else begin
          if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          chk(id, "ack_port", {28'd0, ack}, {28'd0, e.ack});
          chk(id, "grant_in_done", {28'd0, grant}, {28'd0, e.ack});
          chk(id, "cs_cycles", cs_cnt[id], 32'd4);
          chk(id, "strobe_cycles", stb_cnt[id], 32'd2);
          chk(id, "pin_errors", err_cnt[id], 32'd0);
          if (e.rd) chk(id, "rdata", {24'd0, rd}, {24'd0, e.rdv});
        end
        cs_cnt[id]  = 0;
        stb_cnt[id] = 0;
        err_cnt[id] = 0;
      end
    end
  endtask

  always @(negedge clk) mon_step(0, rst0_n, {2'b00, ack0}, {2'b00, grant0}, cs0, we_n0,
                                 oe_n0, dq_oe0, ad0, dq_o0, rdata0);
  always @(negedge clk) mon_step(1, rst1_n, ack1, grant1, cs1, we_n1,
                                 oe_n1, dq_oe1, ad1, dq_o1, rdata1);

  // Single access on dut0 from port p; checks ack latency from sampling edge.
  task automatic run0(input int p, input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] rdv);
    int  n;
    logic got;
    @(posedge clk); #1;
    rw0[p]               = r;
    addr0[p*AW +: AW]    = a;
    wdata0[p*DW +: DW]   = d;
    req0[p]              = 1'b1;
    q0.push_back(mk_exp(p, r, a, d, rdv));
    @(posedge clk);  // sampling edge E0
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      if (ack0[p]) got = 1'b1;
      else begin @(posedge clk); n++; end
    end
    chk(0, "latency", n, 32'd3);
    @(posedge clk); #1;
    req0[p] = 1'b0;
  endtask

  initial begin
    int n, gap;
    logic got;
    rst0_n = 1'b0; rst1_n = 1'b0;
    req0 = '0; rw0 = '0; addr0 = '0; wdata0 = '0; dq_i0 = '0;
    req1 = '0; rw1 = '0; addr1 = '0; wdata1 = '0; dq_i1 = '0;
    #1;
    chk(0, "rst_ack",   {30'd0, ack0},   32'd0);
    chk(0, "rst_grant", {30'd0, grant0}, 32'd0);
    chk(0, "rst_busy",  {31'd0, busy0},  32'd0);
    chk(0, "rst_rdata", {24'd0, rdata0}, 32'd0);
    chk(0, "rst_pins",  {28'd0, cs0, we_n0, oe_n0, dq_oe0}, 32'b0110);
    chk(0, "rst_ad",    {15'd0, ad0},    32'd0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Single read, then single write.
    dq_i0 = 8'h5A;
    run0(0, 1'b1, 17'h1E6A0, 8'h00, 8'h5A);
    run0(1, 1'b0, 17'h00100, 8'hC3, 8'h00);
    @(negedge clk);
    chk(0, "rdata_hold", {24'd0, rdata0}, 32'h5A);

    // Fixed priority with both ports requesting continuously.
    @(posedge clk); #1;
    dq_i0 = 8'h3C;
    rw0 = 2'b11;
    addr0 = {17'h000B1, 17'h000A0};
    repeat (3) q0.push_back(mk_exp(0, 1'b1, 17'h000A0, 8'h00, 8'h3C));
    req0 = 2'b11;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (ack0 != 2'b00) n++;
    end
    chk(0, "fixed_acks", n, 32'd3);
    @(posedge clk); #1;
    req0 = 2'b00;

    // Back-to-back on port 0: one IDLE cycle between accesses.
    @(posedge clk); #1;
    addr0[0 +: AW] = 17'h00042;
    repeat (2) q0.push_back(mk_exp(0, 1'b1, 17'h00042, 8'h00, 8'h3C));
    req0 = 2'b01;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack0[0]) got = 1'b1;
    end
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!busy0) gap++;
      else break;
    end
    chk(0, "b2b_idle_gap", gap, 32'd1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack0[0]) got = 1'b1;
    end
    chk(0, "b2b_second_ack", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    req0 = 2'b00;

    // Reset in the middle of a write, then port 0 must win first.
    @(posedge clk); #1;
    rw0[1] = 1'b0;
    addr0[AW +: AW] = 17'h1FFFF;
    wdata0[DW +: DW] = 8'h99;
    req0 = 2'b10;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (!we_n0) got = 1'b1;
    end
    chk(0, "reached_write_strobe", {31'd0, got}, 32'd1);
    #1 rst0_n = 1'b0;
    #1;
    chk(0, "abort_pins",  {28'd0, cs0, we_n0, oe_n0, dq_oe0}, 32'b0110);
    chk(0, "abort_ack",   {30'd0, ack0},   32'd0);
    chk(0, "abort_grant", {30'd0, grant0}, 32'd0);
    chk(0, "abort_busy",  {31'd0, busy0},  32'd0);
    chk(0, "abort_rdata", {24'd0, rdata0}, 32'd0);
    @(posedge clk); #1;
    rw0 = 2'b11;
    addr0[0 +: AW] = 17'h00007;
    q0.push_back(mk_exp(0, 1'b1, 17'h00007, 8'h00, 8'h3C));
    req0 = 2'b11;
    @(negedge clk);
    rst0_n = 1'b1;
    @(posedge clk);  // first arbitration edge
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      if (ack0 != 2'b00) got = 1'b1;
      else begin @(posedge clk); n++; end
    end
    chk(0, "post_reset_latency", n, 32'd3);
    @(posedge clk); #1;
    req0 = 2'b00;

    // Round-robin on dut1, all four ports held: order 0,1,2,3,0.
    @(posedge clk); #1;
    dq_i1 = 8'hA5;
    rw1 = 4'b0101;
    for (int p = 0; p < 4; p++) begin
      addr1[p*AW +: AW]  = AW'(17'h00100 + p);
      wdata1[p*DW +: DW] = DW'(8'h10 + p);
    end
    q1.push_back(mk_exp(0, 1'b1, 17'h00100, 8'h10, 8'hA5));
    q1.push_back(mk_exp(1, 1'b0, 17'h00101, 8'h11, 8'h00));
    q1.push_back(mk_exp(2, 1'b1, 17'h00102, 8'h12, 8'hA5));
    q1.push_back(mk_exp(3, 1'b0, 17'h00103, 8'h13, 8'h00));
    q1.push_back(mk_exp(0, 1'b1, 17'h00100, 8'h10, 8'hA5));
    req1 = 4'b1111;
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (ack1 != 4'd0) n++;
    end
    chk(1, "rr_acks", n, 32'd5);
    @(posedge clk); #1;
    req1 = 4'b0000;

    repeat (8) @(negedge clk);
    chk(0, "queue_drained", q0.size(), 32'd0);
    chk(1, "queue_drained", q1.size(), 32'd0);
    chk(0, "final_idle", {31'd0, busy0}, 32'd0);
    chk(1, "final_idle", {31'd0, busy1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
